// File: rtl/sd_loader_mem_writer.sv
// Single-byte Spectrum memory writer for the SD loader: takes the Z80 bus via
// BUSRQ/BUSAK, drives one MREQ/WR strobe of programmable width, then releases the bus.
module sd_loader_mem_writer #(
  parameter int WR_CYCLES   = 4,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr_in,
  input  logic [7:0]  data_in,
  input  logic        wr_req,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_oe,
  output logic        mreq_n,
  output logic        wr_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_STROBE, S_HOLD, S_RELEASE, S_ERR
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] WR_LAST      = 16'(WR_CYCLES - 1);

  state_t                 state, state_next;
  logic [15:0]            cnt, cnt_next;
  logic                   wr_req_d;
  logic [SYNC_STAGES-1:0] busak_sync;
  logic                   busak_s;
  logic                   start;
  logic                   latch;
  logic                   done_next, error_next;

  assign busak_s = busak_sync[SYNC_STAGES-1];
  assign start   = wr_req & ~wr_req_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = done;
    error_next = error;
    latch      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        latch      = 1'b1;
        done_next  = 1'b0;
        error_next = 1'b0;
        cnt_next   = '0;
        state_next = S_REQ;
      end
      S_REQ: begin
        // An acknowledge arriving on the timeout cycle still proceeds.
        if (!busak_s) begin
          state_next = S_SETUP;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = S_ERR;
          error_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_SETUP: begin
        state_next = S_STROBE;
        cnt_next   = '0;
      end
      S_STROBE: begin
        if (cnt == WR_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_HOLD: begin
        state_next = S_RELEASE;
        cnt_next   = '0;
      end
      S_RELEASE: begin
        if (busak_s) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = S_ERR;
          error_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so they are
  // glitch-free, line up with the state, and drop to idle as soon as reset asserts.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_req_d   <= 1'b0;
      busak_sync <= '1;
      done       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      busrq_n    <= 1'b1;
      mem_oe     <= 1'b0;
      mreq_n     <= 1'b1;
      wr_n       <= 1'b1;
      mem_addr   <= '0;
      mem_dout   <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      wr_req_d   <= wr_req;
      busak_sync <= {busak_sync[SYNC_STAGES-2:0], busak_n};
      done       <= done_next;
      error      <= error_next;
      busy       <= (state_next != S_IDLE);
      busrq_n    <= !(state_next inside {S_REQ, S_SETUP, S_STROBE, S_HOLD});
      mem_oe     <= (state_next inside {S_SETUP, S_STROBE, S_HOLD});
      mreq_n     <= (state_next != S_STROBE);
      wr_n       <= (state_next != S_STROBE);
      if (latch) begin
        mem_addr <= addr_in;
        mem_dout <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_sd_loader_mem_writer.sv
// Directed bench for sd_loader_mem_writer: a table of transactions run against a
// simple Z80 bus-acknowledge model, plus hand sequences for ignored edges and reset.
module tb_sd_loader_mem_writer;

  localparam int WR = 4, TO = 16, SS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic        wr_req;
  logic        busy, done, error;
  logic        busrq_n;
  logic        busak_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_oe, mreq_n, wr_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sd_loader_mem_writer #(.WR_CYCLES(WR), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .data_in(data_in),
    .wr_req(wr_req), .busy(busy), .done(done), .error(error),
    .busrq_n(busrq_n), .busak_n(busak_n), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_oe(mem_oe), .mreq_n(mreq_n), .wr_n(wr_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ak/rel: cycles of busrq_n low (high) before the bus model drops (raises)
  // busak_n; -1 means it never answers.
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          ak;
    int          rel;
    logic        exp_done;
    logic        exp_err;
    int          exp_strobe;
    int          exp_rq;
  } vec_t;

  task automatic run_txn(input string tag, input logic [15:0] addr, input logic [7:0] data,
                         input int ak, input int rel, input bit glitch,
                         input logic exp_done, input logic exp_err,
                         input int exp_strobe, input int exp_rq);
    int req_wait = 0, rel_wait = 0, strobe = 0, pulses = 0, rq = 0;
    int oe_bad = 0, bus_bad = 0, glitch_at = -10;
    bit seen_busy = 0, finished = 0, prev_mreq = 1;
    @(negedge clk);
    addr_in = addr;
    data_in = data;
    wr_req  = 1'b1;
    for (int n = 0; n < 300 && !finished; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check({tag, "_busy_on"}, busy, 1'b1);
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_err_clr"}, error, 1'b0);
        check({tag, "_addr_latch"}, mem_addr, addr);
        check({tag, "_data_latch"}, mem_dout, data);
        addr_in = ~addr;
        data_in = ~data;
      end
      if (n == 2 && !glitch) wr_req = 1'b0;
      if (glitch && n == glitch_at + 1) wr_req = 1'b1;
      if (!busrq_n) rq++;
      if (mem_oe && busrq_n) oe_bad++;
      if (!mreq_n) begin
        strobe++;
        if (prev_mreq) begin
          pulses++;
          if (glitch && pulses == 1) begin
            addr_in   = 16'h5B00;
            wr_req    = 1'b0;
            glitch_at = n;
          end
        end
        if (mem_addr !== addr || mem_dout !== data || wr_n !== 1'b0 || mem_oe !== 1'b1)
          bus_bad++;
      end else if (wr_n !== 1'b1) begin
        bus_bad++;
      end
      prev_mreq = mreq_n;
      if (!busrq_n && busak_n) begin
        req_wait++;
        if (req_wait == ak) busak_n = 1'b0;
      end else if (busrq_n && !busak_n) begin
        rel_wait++;
        if (rel_wait == rel) busak_n = 1'b1;
      end
      if (busy) seen_busy = 1;
      else if (seen_busy) finished = 1;
    end
    check({tag, "_finished"}, finished, 1'b1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_strobe_cycles"}, strobe, exp_strobe);
    check({tag, "_pulses"}, pulses, (exp_strobe > 0) ? 1 : 0);
    check({tag, "_busrq_cycles"}, rq, exp_rq);
    check({tag, "_oe_without_bus"}, oe_bad, 0);
    check({tag, "_bus_values"}, bus_bad, 0);
    check({tag, "_addr_held"}, mem_addr, addr);
    wr_req  = 1'b0;
    busak_n = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_stays_idle"}, busy, 1'b0);
  endtask

  vec_t vecs[7];
  bit   found;

  initial begin
    vecs[0] = '{16'h4000, 8'hA5,  3,  2, 1'b1, 1'b0, 4, 11};
    vecs[1] = '{16'h8000, 8'h11,  1,  1, 1'b1, 1'b0, 4,  9};
    vecs[2] = '{16'h8001, 8'h22,  5,  3, 1'b1, 1'b0, 4, 13};
    vecs[3] = '{16'hFFFF, 8'h00, -1,  1, 1'b0, 1'b1, 0, 16};
    vecs[4] = '{16'h0000, 8'hFF, 14,  2, 1'b1, 1'b0, 4, 22};
    vecs[5] = '{16'h1234, 8'h5A, 15,  2, 1'b0, 1'b1, 0, 16};
    vecs[6] = '{16'h2000, 8'hC3,  2, -1, 1'b0, 1'b1, 4, 10};

    reset_n = 1'b0;
    busak_n = 1'b1;
    wr_req  = 1'b0;
    addr_in = 16'h1111;
    data_in = 8'h99;
    #12;
    check("rst_busrq_n", busrq_n, 1'b1);
    check("rst_mreq_n", mreq_n, 1'b1);
    check("rst_wr_n", wr_n, 1'b1);
    check("rst_mem_oe", mem_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_dout", mem_dout, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].ak, vecs[i].rel,
              1'b0, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_strobe, vecs[i].exp_rq);

    // Second edge and new address during STROBE must be ignored.
    run_txn("glitch", 16'h4000, 8'hA5, 3, 2, 1'b1, 1'b1, 1'b0, 4, 11);

    // Reset asserted mid-strobe drops every bus output at once.
    @(negedge clk);
    addr_in = 16'h6000;
    data_in = 8'h77;
    wr_req  = 1'b1;
    busak_n = 1'b0;
    found   = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (!mreq_n) found = 1;
    end
    check("rstmid_strobe_seen", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_mreq_n", mreq_n, 1'b1);
    check("rstmid_wr_n", wr_n, 1'b1);
    check("rstmid_busrq_n", busrq_n, 1'b1);
    check("rstmid_mem_oe", mem_oe, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    busak_n = 1'b1;
    wr_req  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_after_busy", busy, 1'b0);
    check("rstmid_after_done", done, 1'b0);
    check("rstmid_after_busrq", busrq_n, 1'b1);
    check("rstmid_after_mreq", mreq_n, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_loader_mem_writer.md
Name: sd_loader_mem_writer

Overview:
- Consumes the 16-bit address from the SD-loader address PIO, plus data and strobe PIOs, and performs one byte write into Spectrum memory per request.
- Takes the Z80 bus via BUSRQ/BUSAK, drives address, data, MREQ and WR for a programmed width, then releases the bus.
- Sits between the Nios PIO bank and the Spectrum memory bus arbiter.
- Status is read back through an input PIO: busy, done, error.

Parameters:
- WR_CYCLES, 4: clk cycles that mreq_n/wr_n are held low (legal 1..255).
- TIMEOUT, 1023: max clk cycles to wait for busak_n in REQ or RELEASE (legal 1..65535).
- SYNC_STAGES, 2: flip-flop stages on the busak_n synchronizer (legal ≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- addr_in  in  16  target address (from address PIO out_port)
- data_in  in  8  byte to write (from data PIO)
- wr_req  in  1  request level from strobe PIO; rising edge starts a write
- busy  out  1  high from accepted edge until return to IDLE
- done  out  1  sticky; set on successful completion, cleared on next accepted rising edge
- error  out  1  sticky; set on timeout, cleared on next accepted rising edge
- busrq_n  out  1  Z80 bus request, active low
- busak_n  in  1  Z80 bus acknowledge, active low, asynchronous to clk
- mem_addr  out  16  memory address
- mem_dout  out  8  memory write data
- mem_oe  out  1  high while this block drives mem_addr/mem_dout (tristate enable)
- mreq_n  out  1  memory request, active low
- wr_n  out  1  write strobe, active low

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busrq_n=1, mreq_n=1, wr_n=1, mem_oe=0, busy=0, done=0, error=0, mem_addr=0, mem_dout=0; counters=0; wr_req edge register=0; synchronizer preset to 1 (bus not acknowledged). Reset mid-operation releases the bus immediately; no partial strobe survives.
- wr_req edge detect: registered previous value; start = wr_req & ~wr_req_d. Edge accepted only in IDLE; edges while busy are ignored (not queued).
- On accepted edge: latch addr_in → mem_addr, data_in → mem_dout; clear done and error; busy=1; go to REQ. Latched values are stable for the whole transaction regardless of later PIO writes.
- REQ: busrq_n=0; count cycles. Synced busak_n=0 → SETUP, counter cleared. Counter reaches TIMEOUT → ERR.
- SETUP (1 cycle): mem_oe=1, strobes high.
- STROBE: mem_oe=1, mreq_n=0, wr_n=0 for exactly WR_CYCLES cycles → HOLD.
- HOLD (1 cycle): mem_oe=1, strobes high (address/data hold time).
- RELEASE: mem_oe=0, busrq_n=1; wait for synced busak_n=1 → IDLE with done=1, busy=0. Timeout here → ERR.
- ERR (1 cycle): busrq_n=1, mem_oe=0, strobes high; error=1 → IDLE, busy=0. done stays 0.
- Transaction with immediate busak (already low): REQ lasts SYNC_STAGES+1 cycles minimum due to synchronizer latency.
- mreq_n/wr_n are glitch-free registered outputs; mem_oe is never high while busrq_n=1.
- Simultaneous timeout and busak arrival on the same cycle: busak wins (proceed).

Test Plan:
- Reset with busak_n=1 → all outputs at reset values; busrq_n=1, mem_oe=0, busy=0.
- addr_in=0x4000, data_in=0xA5, wr_req 0→1, busak_n answers 3 cycles after busrq_n low → mem_addr=0x4000, mem_dout=0xA5, mreq_n/wr_n low exactly 4 cycles, oe covers SETUP..HOLD; after busak_n returns high, done=1, busy=0.
- busak_n stuck high, TIMEOUT=16 → busrq_n released after 16 cycles in REQ, error=1, done=0, mreq_n never low.
- Change addr_in to 0x5B00 and toggle wr_req again during STROBE → second edge ignored; mem_addr stays 0x4000; exactly one write.
- Back-to-back: edge for 0x8000/0x11, then after done an edge for 0x8001/0x22 → done clears on second edge, two separate bus cycles with correct values.
- Assert reset_n low during STROBE → same-cycle mreq_n=wr_n=busrq_n=1, mem_oe=0; after release, state IDLE, no done.
